fixed_abs_offset_128: RTL and testbench



---
 rtl/fixed_abs_offset_128_if.sv | 33 +++
 rtl/fixed_abs_offset_128.sv | 90 +++++++++
 tb/tb_fixed_abs_offset_128.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fixed_abs_offset_128_if.sv
// Bus for the fixed_abs_offset_128 custom instruction.
//
// Handshake: start is a single-cycle strobe. It is qualified by clk_en on
// the same rising edge. done rises for exactly one cycle, two edges after
// each qualified start. There is no back-pressure. result is meaningful
// whenever done is high, but it is also updated every cycle.
interface fixed_abs_offset_128_if #(
    parameter int FRAC_BITS = 13
);
    logic                     clk_en;
    logic                     start;
    logic [31:0]              dataa;
    logic [8+FRAC_BITS-1:0]   result;
    logic                     done;

    // Processor side drives the operand and strobes.
    modport master (
        output clk_en,
        output start,
        output dataa,
        input  result,
        input  done
    );

    // Datapath side returns the result and done strobe.
    modport slave (
        input  clk_en,
        input  start,
        input  dataa,
        output result,
        output done
    );
endinterface

// File: rtl/fixed_abs_offset_128.sv
// fixed_abs_offset_128: converts an IEEE-754 single to unsigned Q8.FRAC_BITS,
// then returns |x - 128.0|. The block is a two-stage pipeline with a fixed
// latency of 2 cycles and accepts one operand per cycle.
// done is a 2-deep delayed copy of (start & clk_en).
module fixed_abs_offset_128 #(
    parameter int FRAC_BITS = 13
) (
    input  logic                   clock,
    input  logic                   reset,
    fixed_abs_offset_128_if.slave  bus
);
    localparam int RW = 8 + FRAC_BITS;

    // Mantissa {1,m} is an integer scaled by 2^(e-150). In fixed point with
    // FRAC_BITS fraction bits, it lands at a right shift of (150-FRAC_BITS) - e.
    localparam logic [7:0] SHIFT_BASE = 8'(150 - FRAC_BITS);
    // Below this exponent, even the hidden bit falls under 2^-FRAC_BITS.
    localparam logic [7:0] E_MIN      = 8'(150 - FRAC_BITS - 23);
    // 2^8 = 256.0 does not fit in the 8 integer bits.
    localparam logic [7:0] E_SAT      = 8'd135;
    // 128.0 in Q8.FRAC_BITS, extended by one sign bit.
    localparam logic [RW:0] OFFSET    = {2'b01, {(RW-1){1'b0}}};

    logic          sign_f;
    logic [7:0]    exp_f;
    logic [22:0]   man_f;
    logic [23:0]   mant_full;
    logic [7:0]    shift_amt;
    logic [23:0]   mant_shifted;

    logic [RW-1:0] fixed_d, fixed_q;
    logic [RW:0]   diff_pos, diff_neg;
    logic [RW-1:0] result_d, result_q;
    logic [1:0]    done_d, done_q;

    assign sign_f    = bus.dataa[31];
    assign exp_f     = bus.dataa[30:23];
    assign man_f     = bus.dataa[22:0];
    assign mant_full = {1'b1, man_f};
    assign shift_amt = SHIFT_BASE - exp_f;
    // Only used when E_MIN <= e < E_SAT, so the shift stays within 3..23.
    assign mant_shifted = mant_full >> shift_amt[4:0];

    // Stage 1: float to unsigned fixed point, clamping and saturating at the ends of the range.
    always_comb begin
        fixed_d = '0;
        if (exp_f == 8'd0 || sign_f) begin
            fixed_d = '0;
        end else if (exp_f >= E_SAT) begin
            // Covers +inf and positive NaN (e == 255) as well.
            fixed_d = '1;
        end else if (exp_f < E_MIN) begin
            fixed_d = '0;
        end else begin
            fixed_d = mant_shifted[RW-1:0];
        end
    end

    assign diff_pos = {1'b0, fixed_q} - OFFSET;
    assign diff_neg = OFFSET - {1'b0, fixed_q};

    // Stage 2: distance from 128.0. The sign bit of the widened difference picks the branch.
    always_comb begin
        result_d = diff_pos[RW-1:0];
        if (diff_pos[RW]) begin
            result_d = diff_neg[RW-1:0];
        end
    end

    // The done chain follows the datapath depth, so each done lines up with its operand.
    always_comb begin
        done_d = {done_q[0], bus.start & bus.clk_en};
    end

    // Pipeline registers. The datapath advances every cycle. Reset flushes everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            fixed_q  <= '0;
            result_q <= '0;
            done_q   <= '0;
        end else begin
            fixed_q  <= fixed_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q[1];
endmodule

// File: tb/tb_fixed_abs_offset_128.sv
// Directed bench for fixed_abs_offset_128. Inputs are driven on the falling
// edge, and outputs are sampled on the falling edge before new inputs are applied.
module tb_fixed_abs_offset_128;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    fixed_abs_offset_128_if #(.FRAC_BITS(13)) bus ();

    fixed_abs_offset_128 #(.FRAC_BITS(13)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.clk_en = 1'b0;
        bus.dataa = 32'h4316_0000;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus.dataa = 32'h0000_0000;
        total_cnt++;
        if (bus.result !== 21'h0) $display("FAIL reset_result got=%h exp=%h", bus.result, 21'h0);
        else pass_cnt++;
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done);
        else pass_cnt++;
        @(negedge clock);
        @(negedge clock);
        total_cnt++;
        if (bus.result !== 21'h100000) $display("FAIL reset_release got=%h exp=%h", bus.result, 21'h100000);
        else pass_cnt++;
    endtask

    // Streams one operand per cycle and checks each result two cycles later.
    task automatic test_stream_low();
        logic [31:0] vin [7];
        logic [20:0] vexp [7];
        vin  = '{32'h0000_0000, 32'h41C8_0000, 32'h4248_0000, 32'h4296_0000,
                 32'h42C8_0000, 32'h42FA_0000, 32'h4316_0000};
        vexp = '{21'h100000, 21'h0CE000, 21'h09C000, 21'h06A000,
                 21'h038000, 21'h006000, 21'h02C000};
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                total_cnt++;
                if (bus.result !== vexp[i-2])
                    $display("FAIL stream_low[%0d] in=%h got=%h exp=%h", i-2, vin[i-2], bus.result, vexp[i-2]);
                else pass_cnt++;
            end
            if (i < 7) bus.dataa = vin[i];
        end
    endtask

    task automatic test_stream_high();
        logic [31:0] vin [5];
        logic [20:0] vexp [5];
        vin  = '{32'h432F_0000, 32'h4348_0000, 32'h4361_0000, 32'h437A_0000, 32'h437F_0000};
        vexp = '{21'h05E000, 21'h090000, 21'h0C2000, 21'h0F4000, 21'h0FE000};
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                total_cnt++;
                if (bus.result !== vexp[i-2])
                    $display("FAIL stream_high[%0d] in=%h got=%h exp=%h", i-2, vin[i-2], bus.result, vexp[i-2]);
                else pass_cnt++;
            end
            if (i < 5) bus.dataa = vin[i];
        end
    endtask

    // Exact match, fractions, saturation, negatives, infinities, denormals, LSB boundary.
    task automatic test_edges();
        logic [31:0] vin [11];
        logic [20:0] vexp [11];
        vin  = '{32'h4300_0000, 32'h42FF_0000, 32'h4396_0000, 32'hC0A0_0000,
                 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001, 32'h3880_0000,
                 32'h3900_0000, 32'h4380_0000, 32'h437F_FFFF};
        vexp = '{21'h000000, 21'h001000, 21'h0FFFFF, 21'h100000,
                 21'h0FFFFF, 21'h100000, 21'h100000, 21'h100000,
                 21'h0FFFFF, 21'h0FFFFF, 21'h0FFFFF};
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                total_cnt++;
                if (bus.result !== vexp[i-2])
                    $display("FAIL edge[%0d] in=%h got=%h exp=%h", i-2, vin[i-2], bus.result, vexp[i-2]);
                else pass_cnt++;
            end
            if (i < 11) bus.dataa = vin[i];
        end
    endtask

    task automatic test_single_done();
        logic expd [4];
        expd = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c >= 1) begin
                total_cnt++;
                if (bus.done !== expd[c]) $display("FAIL single_done[%0d] got=%b exp=%b", c, bus.done, expd[c]);
                else pass_cnt++;
            end
            bus.start  = (c == 0);
            bus.clk_en = 1'b1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_unqualified_start();
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c >= 1) begin
                total_cnt++;
                if (bus.done !== 1'b0) $display("FAIL noen_done[%0d] got=%b exp=0", c, bus.done);
                else pass_cnt++;
            end
            bus.start  = (c == 0);
            bus.clk_en = 1'b0;
        end
        bus.start = 1'b0;
        bus.clk_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic expd [6];
        expd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            total_cnt++;
            if (bus.done !== expd[c]) $display("FAIL b2b_done[%0d] got=%b exp=%b", c, bus.done, expd[c]);
            else pass_cnt++;
            bus.start  = (c < 3);
            bus.clk_en = 1'b1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [20:0] expr [3];
        expr = '{21'h000000, 21'h100000, 21'h038000};
        @(negedge clock);
        bus.start  = 1'b1;
        bus.clk_en = 1'b1;
        bus.dataa  = 32'h4300_0000;
        @(negedge clock);
        bus.start = 1'b0;
        reset     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            total_cnt++;
            if (bus.done !== 1'b0) $display("FAIL rst_mid_done[%0d] got=%b exp=0", c, bus.done);
            else pass_cnt++;
            total_cnt++;
            if (bus.result !== expr[c]) $display("FAIL rst_mid_result[%0d] got=%h exp=%h", c, bus.result, expr[c]);
            else pass_cnt++;
            reset     = 1'b0;
            bus.dataa = 32'h42C8_0000;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_stream_low();
        test_stream_high();
        test_edges();
        test_single_done();
        test_unqualified_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
